// File: rtl/hls_channel_pkg.sv
// Shared definitions for the HLS kernel channel FIFO and the kernel wrappers that connect to it.
package hls_channel_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 16;

  // Bits needed to encode values 0..value-1; at least 1 so a DEPTH of 1 still has a valid index.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // One direction of a kernel channel as seen by a kernel wrapper.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
    logic                     valid;
    logic                     ready;
    logic                     rst;
  } channel_bus_t;

endpackage

// File: rtl/channel_ram.sv
// WIDTH x DEPTH register file: one synchronous write port, one asynchronous read port.
module channel_ram
  import hls_channel_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; the FIFO only exposes words it has written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hls_channel_fifo.sv
// Responder end of an HLS kernel channel: circular-buffer FIFO with registered pop data
// and ready flags decoded from the registered occupancy.
module hls_channel_fifo
  import hls_channel_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        soft_rst,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        write_valid,
  output logic                        write_ready,
  input  logic                        read_valid,
  output logic                        read_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] ram_rdata;
  logic             ram_we;
  logic             wr, rd;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign write_ready = (cnt_q != CW'(DEPTH));
  assign read_ready  = (cnt_q != '0);
  assign out_data    = out_q;
  assign count       = cnt_q;

  channel_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wp_q),
    .wdata_i (in_data),
    .raddr_i (rp_q),
    .rdata_o (ram_rdata)
  );

  // Next-state: flush wins over both ports; acceptance uses the registered flags only.
  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    ram_we = 1'b0;
    wr     = write_valid & write_ready;
    rd     = read_valid & read_ready;
    if (soft_rst) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      out_d = '0;
    end else begin
      if (wr) begin
        ram_we = 1'b1;
        wp_d   = ptr_inc(wp_q);
      end
      if (rd) begin
        out_d = ram_rdata;
        rp_d  = ptr_inc(rp_q);
      end
      if (wr && !rd) begin
        cnt_d = cnt_q + CW'(1);
      end else if (rd && !wr) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_hls_channel_fifo.sv
// Self-checking bench for hls_channel_fifo: directed scenarios plus random traffic against a queue model.
module tb_hls_channel_fifo;

  logic clk = 1'b0;
  logic rst;
  logic sr;

  logic        w4v, r4v, wr4, rr4;
  logic [31:0] w4d, o4;
  logic [2:0]  c4;
  logic        w5v, r5v, wr5, rr5;
  logic [31:0] w5d, o5;
  logic [2:0]  c5;

  logic [31:0] m4[$];
  logic [31:0] m5[$];
  logic [31:0] m4_out;
  logic [31:0] m5_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hls_channel_fifo #(.WIDTH(32), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .soft_rst(sr),
    .in_data(w4d), .write_valid(w4v), .write_ready(wr4),
    .read_valid(r4v), .read_ready(rr4), .out_data(o4), .count(c4)
  );

  hls_channel_fifo #(.WIDTH(32), .DEPTH(5)) u5 (
    .clk(clk), .rst(rst), .soft_rst(sr),
    .in_data(w5d), .write_valid(w5v), .write_ready(wr5),
    .read_valid(r5v), .read_ready(rr5), .out_data(o5), .count(c5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of traffic on the DEPTH=4 channel; the model pops before pushing (no bypass).
  task automatic cyc4(input bit wv, input logic [31:0] wd, input bit rv);
    bit can_r, can_w;
    w4v = wv; w4d = wd; r4v = rv;
    can_r = (m4.size() != 0);
    can_w = (m4.size() < 4);
    if (rv && can_r) m4_out = m4.pop_front();
    if (wv && can_w) m4.push_back(wd);
    step();
    w4v = 1'b0; r4v = 1'b0;
  endtask

  task automatic cyc5(input bit wv, input logic [31:0] wd, input bit rv);
    bit can_r, can_w;
    w5v = wv; w5d = wd; r5v = rv;
    can_r = (m5.size() != 0);
    can_w = (m5.size() < 5);
    if (rv && can_r) m5_out = m5.pop_front();
    if (wv && can_w) m5.push_back(wd);
    step();
    w5v = 1'b0; r5v = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (wr4 !== 1'b1) begin n_err++; $display("FAIL reset_write_ready got %0b want 1", wr4); end
    n_cmp++; if (rr4 !== 1'b0) begin n_err++; $display("FAIL reset_read_ready got %0b want 0", rr4); end
    n_cmp++; if (o4 !== 32'd0) begin n_err++; $display("FAIL reset_out_data got %0d want 0", o4); end
    n_cmp++; if (c4 !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", c4); end
    #10 rst = 1'b1;
    step();
    cyc4(1'b1, 32'd7, 1'b0);
    n_cmp++; if (rr4 !== 1'b1) begin n_err++; $display("FAIL basic_read_ready got %0b want 1", rr4); end
    cyc4(1'b0, 32'd0, 1'b1);
    n_cmp++; if (o4 !== 32'd7) begin n_err++; $display("FAIL basic_out_data got %0d want 7", o4); end
    n_cmp++; if (c4 !== 3'd0) begin n_err++; $display("FAIL basic_count got %0d want 0", c4); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 4; i++) begin
      cyc4(1'b1, 32'(i), 1'b0);
      n_cmp++; if (c4 !== 3'(i)) begin n_err++; $display("FAIL fill_count got %0d want %0d", c4, i); end
    end
    n_cmp++; if (wr4 !== 1'b0) begin n_err++; $display("FAIL full_write_ready got %0b want 0", wr4); end
    cyc4(1'b1, 32'd5, 1'b0);
    n_cmp++; if (c4 !== 3'd4) begin n_err++; $display("FAIL overflow_count got %0d want 4", c4); end
    for (int i = 1; i <= 4; i++) begin
      cyc4(1'b0, 32'd0, 1'b1);
      n_cmp++; if (o4 !== 32'(i)) begin n_err++; $display("FAIL drain_order got %0d want %0d", o4, i); end
    end
  endtask

  task automatic test_full_simul();
    for (int i = 1; i <= 4; i++) cyc4(1'b1, 32'(i), 1'b0);
    cyc4(1'b1, 32'd9, 1'b1);
    n_cmp++; if (o4 !== 32'd1) begin n_err++; $display("FAIL full_rw_out got %0d want 1", o4); end
    n_cmp++; if (c4 !== 3'd3) begin n_err++; $display("FAIL full_rw_count got %0d want 3", c4); end
    n_cmp++; if (wr4 !== 1'b1) begin n_err++; $display("FAIL full_rw_write_ready got %0b want 1", wr4); end
    cyc4(1'b1, 32'd9, 1'b0);
    n_cmp++; if (c4 !== 3'd4) begin n_err++; $display("FAIL retry_count got %0d want 4", c4); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp;
      exp = (i == 3) ? 32'd9 : 32'(i + 2);
      cyc4(1'b0, 32'd0, 1'b1);
      n_cmp++; if (o4 !== exp) begin n_err++; $display("FAIL full_rw_drain got %0d want %0d", o4, exp); end
    end
  endtask

  task automatic test_empty_simul();
    cyc4(1'b1, 32'd5, 1'b1);
    n_cmp++; if (c4 !== 3'd1) begin n_err++; $display("FAIL empty_rw_count got %0d want 1", c4); end
    n_cmp++; if (o4 !== 32'd9) begin n_err++; $display("FAIL empty_rw_out_held got %0d want 9", o4); end
    cyc4(1'b0, 32'd0, 1'b1);
    n_cmp++; if (o4 !== 32'd5) begin n_err++; $display("FAIL empty_rw_next_read got %0d want 5", o4); end
  endtask

  // A 4-word reduction kernel on the read side: poll read_ready, pulse read_valid, sample next cycle.
  task automatic test_kernel_pairing();
    logic [31:0] kout;
    kout = 32'd0;
    for (int i = 1; i <= 4; i++) cyc4(1'b1, 32'(i), 1'b0);
    for (int k = 0; k < 4; k++) begin
      int guard;
      guard = 0;
      while (!rr4 && guard < 20) begin
        step();
        guard++;
      end
      if (guard >= 20) begin
        n_cmp++; n_err++;
        $display("FAIL kernel_poll_timeout got read_ready=%0b want 1", rr4);
      end
      cyc4(1'b0, 32'd0, 1'b1);
      kout = kout + o4;
    end
    n_cmp++; if (kout !== 32'd10) begin n_err++; $display("FAIL kernel_sum got %0d want 10", kout); end
  endtask

  task automatic test_stream_wrap();
    logic [31:0] words [40];
    for (int i = 0; i < 40; i++) words[i] = $urandom;
    cyc5(1'b1, words[0], 1'b0);
    for (int i = 1; i < 40; i++) begin
      cyc5(1'b1, words[i], 1'b1);
      n_cmp++; if (o5 !== words[i-1]) begin n_err++; $display("FAIL stream_word%0d got %h want %h", i - 1, o5, words[i-1]); end
      n_cmp++; if (c5 !== 3'd1) begin n_err++; $display("FAIL stream_count got %0d want 1", c5); end
    end
    cyc5(1'b0, 32'd0, 1'b1);
    n_cmp++; if (o5 !== words[39]) begin n_err++; $display("FAIL stream_last got %h want %h", o5, words[39]); end
    n_cmp++; if (c5 !== 3'd0) begin n_err++; $display("FAIL stream_final_count got %0d want 0", c5); end
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 300; i++) begin
      bit wv, rv;
      wv = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) != 0);
      if (i >= 100 && i < 150) rv = 1'b0;
      if (i >= 200 && i < 250) wv = 1'b0;
      cyc5(wv, $urandom, rv);
      n_cmp++; if (o5 !== m5_out) begin n_err++; $display("FAIL rand_out cycle %0d got %h want %h", i, o5, m5_out); end
      n_cmp++; if (c5 !== 3'(m5.size())) begin n_err++; $display("FAIL rand_count cycle %0d got %0d want %0d", i, c5, m5.size()); end
      n_cmp++; if (wr5 !== (m5.size() < 5)) begin n_err++; $display("FAIL rand_write_ready cycle %0d got %0b", i, wr5); end
      n_cmp++; if (rr5 !== (m5.size() != 0)) begin n_err++; $display("FAIL rand_read_ready cycle %0d got %0b", i, rr5); end
    end
  endtask

  task automatic test_flush_and_reset();
    for (int i = 11; i <= 14; i++) cyc4(1'b1, 32'(i), 1'b0);
    cyc4(1'b0, 32'd0, 1'b1);
    n_cmp++; if (c4 !== 3'd3) begin n_err++; $display("FAIL preflush_count got %0d want 3", c4); end
    n_cmp++; if (o4 !== 32'd11) begin n_err++; $display("FAIL preflush_out got %0d want 11", o4); end
    sr = 1'b1;
    cyc4(1'b1, 32'd99, 1'b1);
    sr = 1'b0;
    m4.delete();
    m4_out = 32'd0;
    m5.delete();
    m5_out = 32'd0;
    n_cmp++; if (c4 !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", c4); end
    n_cmp++; if (rr4 !== 1'b0) begin n_err++; $display("FAIL flush_read_ready got %0b want 0", rr4); end
    n_cmp++; if (o4 !== 32'd0) begin n_err++; $display("FAIL flush_out got %0d want 0", o4); end
    for (int i = 21; i <= 23; i++) cyc4(1'b1, 32'(i), 1'b0);
    cyc4(1'b0, 32'd0, 1'b1);
    n_cmp++; if (o4 !== 32'd21) begin n_err++; $display("FAIL postflush_out got %0d want 21", o4); end
    #3 rst = 1'b0;
    #1;
    n_cmp++; if (o4 !== 32'd0) begin n_err++; $display("FAIL async_rst_out got %0d want 0", o4); end
    n_cmp++; if (c4 !== 3'd0) begin n_err++; $display("FAIL async_rst_count got %0d want 0", c4); end
    n_cmp++; if (rr4 !== 1'b0) begin n_err++; $display("FAIL async_rst_read_ready got %0b want 0", rr4); end
    n_cmp++; if (wr4 !== 1'b1) begin n_err++; $display("FAIL async_rst_write_ready got %0b want 1", wr4); end
    #2 rst = 1'b1;
    m4.delete();
    m4_out = 32'd0;
  endtask

  initial begin
    rst = 1'b0; sr = 1'b0;
    w4v = 1'b0; r4v = 1'b0; w4d = '0;
    w5v = 1'b0; r5v = 1'b0; w5d = '0;
    m4_out = 32'd0;
    m5_out = 32'd0;
    test_reset();
    test_fill_overflow();
    test_full_simul();
    test_empty_simul();
    test_kernel_pairing();
    test_stream_wrap();
    test_random_traffic();
    test_flush_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
